// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional RSA_CTRL_SKIP_LZ_EN: begin the bit loop at the most-significant set exponent bit.
module rsa_modexp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] plain_text,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] mont_const,
    output logic             mm_start,
    output logic             mm_abort,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_TO_M, S_TO_ONE, S_SQ, S_MUL, S_FROM, S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_m, r_exp, r_n, r_c, r_mm;
    logic [IW-1:0]    r_idx;
    logic             r_mm_start, r_mm_abort, r_busy, r_done, r_error;
    logic [WIDTH-1:0] r_mm_a, r_mm_b, r_result;

    state_t           w_nxt;
    logic [WIDTH-1:0] w_a, w_b;
    logic [IW-1:0]    w_i;
    logic             w_cap;

    // The mm_start cycle itself is not part of the wait window.
    assign w_cap = mm_done && !r_mm_start;

`ifdef RSA_CTRL_SKIP_LZ_EN
    logic [IW-1:0] w_msb;
    always_comb begin
        w_msb = '0;
        for (int unsigned k = 0; k < WIDTH; k++)
            if (r_exp[k]) w_msb = IW'(k);
    end
`endif

    // Next multiplier step, applied when the current step completes.
    always_comb begin
        w_nxt = S_DONE;
        w_a   = mm_result;
        w_b   = mm_result;
        w_i   = r_idx;
        unique case (r_state)
            S_TO_M: begin
                w_nxt = S_TO_ONE;
                w_a   = WIDTH'(1);
                w_b   = r_c;
            end
            S_TO_ONE: begin
                w_nxt = S_SQ;
                w_i   = IW'(WIDTH - 1);
`ifdef RSA_CTRL_SKIP_LZ_EN
                if (r_exp == '0) begin
                    w_nxt = S_FROM;
                    w_b   = WIDTH'(1);
                end else begin
                    w_i = w_msb;
                end
`endif
            end
            S_SQ: begin
                if (r_exp[r_idx]) begin
                    w_nxt = S_MUL;
                    w_b   = r_mm;
                end else if (r_idx == '0) begin
                    w_nxt = S_FROM;
                    w_b   = WIDTH'(1);
                end else begin
                    w_nxt = S_SQ;
                    w_i   = r_idx - IW'(1);
                end
            end
            S_MUL: begin
                if (r_idx == '0) begin
                    w_nxt = S_FROM;
                    w_b   = WIDTH'(1);
                end else begin
                    w_nxt = S_SQ;
                    w_i   = r_idx - IW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_m        <= '0;
            r_exp      <= '0;
            r_n        <= '0;
            r_c        <= '0;
            r_mm       <= '0;
            r_idx      <= '0;
            r_mm_start <= 1'b0;
            r_mm_abort <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_result   <= '0;
        end else begin
            r_mm_start <= 1'b0;
            r_mm_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_m     <= plain_text;
                        r_exp   <= exponent;
                        r_n     <= modulus;
                        r_c     <= mont_const;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (stop) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!r_n[0]) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_mm_start <= 1'b1;
                        r_mm_a     <= r_m;
                        r_mm_b     <= r_c;
                        r_state    <= S_TO_M;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    if (stop) begin
                        r_mm_abort <= !w_cap;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_cap) begin
                        if (r_state == S_TO_M) r_mm <= mm_result;
                        if (r_state == S_FROM) begin
                            r_result <= mm_result;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_mm_start <= 1'b1;
                            r_mm_a     <= w_a;
                            r_mm_b     <= w_b;
                            r_idx      <= w_i;
                            r_state    <= w_nxt;
                        end
                    end
                end
            endcase
        end
    end

    assign mm_start = r_mm_start;
    assign mm_abort = r_mm_abort;
    assign mm_a     = r_mm_a;
    assign mm_b     = r_mm_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign result   = r_result;
endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Sequencer for the RSA peripheral's encryption datapath.
- Computes result = plain_text^exponent mod modulus by left-to-right square-and-multiply.
- Drives an external Montgomery multiplier through a start/done handshake.
- Sits between the peripheral register bank (command, plain text, exponent, modulus and Montgomery-constant registers) and the multiplier; feeds the encrypted-data and status read-back.

Parameters:
- WIDTH, 8, operand width in bits (R = 2^WIDTH).

Ports:
- clk  in  1  peripheral clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse, begin operation (command bit 0)
- stop  in  1  one-cycle pulse, abort operation (command bit 1)
- plain_text  in  WIDTH  message M
- exponent  in  WIDTH  exponent e
- modulus  in  WIDTH  modulus n
- mont_const  in  WIDTH  R^2 mod n, supplied by software
- mm_start  out  1  one-cycle pulse, multiplier operation request
- mm_abort  out  1  one-cycle pulse, multiplier flush on stop
- mm_a  out  WIDTH  multiplier operand A
- mm_b  out  WIDTH  multiplier operand B
- mm_done  in  1  one-cycle pulse, mm_result valid
- mm_result  in  WIDTH  A*B*R^-1 mod n
- busy  out  1  operation in progress
- done  out  1  sticky completion flag
- error  out  1  sticky invalid-modulus flag
- result  out  WIDTH  final ciphertext

Behaviour:
- Reset: state IDLE; busy, done, error, mm_start and mm_abort are 0; result, mm_a and mm_b are 0.
- Latching: start accepted only in IDLE. On acceptance, latch M, e, n and mont_const into internal copies; clear done and error. Later input changes have no effect.
- Invalid modulus: if the latched n is even (bit0 = 0), including 0, go to DONE next cycle. Set error = 1 and done = 1. No mm_start is issued; result is unchanged.
- Operation sequence (each step is one multiplier operation):
  - TO_M: Mm = mont(M, C).
  - TO_ONE: A = mont(1, C).
  - SQ: A = mont(A, A).
  - MUL: A = mont(A, Mm), only when e[i] = 1.
  - FROM: result = mont(A, 1).
- Bit loop: index i runs from WIDTH-1 down to 0. SQ then (if e[i] = 1) MUL, then decrement i. After i = 0, go to FROM, then DONE.
- Handshake per operation step:
  - mm_a and mm_b are set in the cycle mm_start pulses and held stable until mm_done.
  - The step then waits for mm_done, capturing mm_result on the mm_done cycle. Next step's mm_start comes the cycle after mm_done at the earliest.
  - mm_done outside a wait is ignored.
- DONE: set done = 1, busy = 0, return to IDLE next cycle. done, error and result hold until the next accepted start or rst.
- busy: 1 from the cycle after start acceptance until the DONE cycle inclusive.
- Exponent 0: all MUL steps are skipped; result = 1 (0 if n = 1).
- Stop:
  - In any non-IDLE state, return to IDLE next cycle and pulse mm_abort if a multiplier operation is outstanding.
  - done and error stay 0; result keeps its previous value.
  - Stop in IDLE has no effect. Start and stop in the same cycle in IDLE: stop wins, nothing starts.
  - Start while busy is ignored.
- rst mid-operation: immediate return to reset values. mm_abort is not pulsed; the multiplier shares rst.
- Multiplier operation count (no optional feature): 3 + WIDTH + popcount(e).

Optional Feature:
- Macro: RSA_CTRL_SKIP_LZ_EN.
- When defined: after TO_ONE, i starts at the index of the most-significant set bit of e, skipping leading-zero squarings. If e = 0, go straight from TO_ONE to FROM. Operation count becomes 3 + (msb_index + 1) + popcount(e), or 3 for e = 0.
- When undefined: i always starts at WIDTH-1. Result is identical in both builds; only latency differs.

Test Plan:
- Bench model: multiplier returns a*b*256^-1 mod n, 4 cycles after mm_start.
- n=0x0D, C=0x03, M=0x02, e=0x0B, start -> done=1, error=0, result=0x07. mm_start count is 14 (10 with RSA_CTRL_SKIP_LZ_EN).
- n=0x33, C=0x01, M=0x05, e=0x03 -> result=0x17. 13 multiplier operations (7 with the feature).
- n=0x0D, C=0x03, M=0x09, e=0x00 -> result=0x01. 11 operations (3 with the feature).
- n=0x10, any operands, start -> error=1 and done=1 two cycles after start, mm_start never asserted, result unchanged.
- Start, then stop during the third multiplier wait -> mm_abort pulses once, busy=0 next cycle, done=0. A second start pulse issued while busy, before the stop, has no effect. A subsequent start with the first test's operands gives result=0x07.
- start and stop asserted in the same cycle in IDLE -> busy stays 0, no mm_start. rst asserted mid-operation -> all outputs 0 next cycle.
